// File: rtl/pulse_train_generator_if.sv
// Start/count request and pulse-train status bundle for pulse_train_generator.
// The master side issues bursts; the slave side (the generator) drives o_sig/o_busy/o_done.
interface pulse_train_generator_if #(
    parameter int CNT_W = 8
);
    logic             i_start;
    logic [CNT_W-1:0] i_count;
    logic             o_sig;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start,
        output i_count,
        input  o_sig,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_count,
        output o_sig,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Registered burst generator: N pulses of HIGH_CYCLES high / LOW_CYCLES low per start strobe.
// Define PULSE_GEN_RETRIGGER_EN to queue one start request received while a burst is running.
module pulse_train_generator #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    pulse_train_generator_if.slave  bus
);

    localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(HIGH_CYCLES);
    localparam logic [PH_W-1:0]  PH_LOW  = PH_W'(LOW_CYCLES);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Request actually presented to the FSM while it sits in IDLE.
    logic             req_valid;
    logic [CNT_W-1:0] req_count;

`ifdef PULSE_GEN_RETRIGGER_EN
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] pend_count_q, pend_count_d;

    // A fresh strobe in IDLE beats a stored one since it is the later request.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_count_d = pend_count_q;
        req_valid    = 1'b0;
        req_count    = '0;
        if (state_q == IDLE) begin
            if (bus.i_start) begin
                req_valid = 1'b1;
                req_count = bus.i_count;
            end else if (pend_valid_q) begin
                req_valid = 1'b1;
                req_count = pend_count_q;
            end
            pend_valid_d = 1'b0;
        end else if (bus.i_start) begin
            pend_valid_d = 1'b1;
            pend_count_d = bus.i_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_valid_q <= 1'b0;
            pend_count_q <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_count_q <= pend_count_d;
        end
    end
`else
    assign req_valid = bus.i_start;
    assign req_count = bus.i_count;
`endif

    // Outputs are computed one cycle ahead so o_sig/o_busy/o_done come straight from flops.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        sig_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_count != '0) begin
                        state_d     = HIGH;
                        phase_d     = PH_HIGH;
                        remaining_d = req_count - CNT_ONE;
                        sig_d       = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            HIGH: begin
                busy_d = 1'b1;
                if (phase_q == PH_ONE) begin
                    state_d = LOW;
                    phase_d = PH_LOW;
                end else begin
                    phase_d = phase_q - PH_ONE;
                    sig_d   = 1'b1;
                end
            end

            LOW: begin
                if (phase_q == PH_ONE) begin
                    if (remaining_q != '0) begin
                        state_d     = HIGH;
                        phase_d     = PH_HIGH;
                        remaining_d = remaining_q - CNT_ONE;
                        sig_d       = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = IDLE;
                        phase_d = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - PH_ONE;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                phase_d     = '0;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            sig_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            sig_q       <= sig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_sig  = sig_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: cycle-exact scoreboard on a H=L=4 instance
// plus several differently parameterised instances driven with random burst lengths.
module tb_pulse_train_generator;

    localparam int BIG = 1000000;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pulse_train_generator_if #(.CNT_W(8)) bus ();

    pulse_train_generator #(
        .HIGH_CYCLES(4),
        .LOW_CYCLES (4),
        .CNT_W      (8)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic sig;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int   main_edges = 0;
    logic main_prev  = 1'b0;

    always_ff @(posedge clk) begin
        main_prev <= bus.o_sig;
        if (bus.o_sig && !main_prev) main_edges <= main_edges + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected waveform of one burst, cycle 1 being the cycle after the accepting edge.
    task automatic push_burst(input int n, input int h, input int l, input int limit);
        exp_t e;
        int   total;
        total = n * (h + l) + 1;
        for (int c = 1; c <= total && c <= limit; c++) begin
            e.sig  = (c <= n * (h + l)) && (((c - 1) % (h + l)) < h);
            e.busy = (c <= n * (h + l));
            e.done = (c == total);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int m);
        exp_t e;
        e = '0;
        for (int i = 0; i < m; i++) exp_q.push_back(e);
    endtask

    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s c%0d o_sig", name, cyc),  32'(bus.o_sig),  32'(e.sig));
            check_eq($sformatf("%s c%0d o_busy", name, cyc), 32'(bus.o_busy), 32'(e.busy));
            check_eq($sformatf("%s c%0d o_done", name, cyc), 32'(bus.o_done), 32'(e.done));
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) tick(name);
    endtask

    task automatic start(input int n);
        bus.i_start = 1'b1;
        bus.i_count = 8'(n);
        cyc = 0;
    endtask

    // Random-length bursts on instances with other phase lengths, edges counted by a clocked detector.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int RH = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 5 : 8;
        localparam int RL = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 3 : 6;

        logic rrst;
        bit   fin = 1'b0;
        int   r_edges  = 0;
        int   low_run  = 0;
        int   min_low  = 1000;
        logic r_prev   = 1'b0;
        int   exp_cnt_q[$];

        pulse_train_generator_if #(.CNT_W(8)) rbus ();

        pulse_train_generator #(
            .HIGH_CYCLES(RH),
            .LOW_CYCLES (RL),
            .CNT_W      (8)
        ) u_rdut (
            .i_clk(clk),
            .i_rst(rrst),
            .bus  (rbus)
        );

        always_ff @(posedge clk) begin
            r_prev <= rbus.o_sig;
            if (rbus.o_sig && !r_prev) begin
                r_edges <= r_edges + 1;
                if (low_run > 0 && low_run < min_low) min_low <= low_run;
                low_run <= 0;
            end else if (!rbus.o_sig && rbus.o_busy) begin
                low_run <= low_run + 1;
            end else if (!rbus.o_busy) begin
                low_run <= 0;
            end
        end

        initial begin
            int n;
            int snap;
            int w;
            int gap;
            int exp_n;
            rrst = 1'b1;
            rbus.i_start = 1'b0;
            rbus.i_count = '0;
            repeat (3) @(posedge clk);
            #1;
            rrst = 1'b0;
            for (int b = 0; b < 10; b++) begin
                n    = int'($urandom_range(0, 20));
                snap = r_edges;
                exp_cnt_q.push_back(n);
                rbus.i_start = 1'b1;
                rbus.i_count = 8'(n);
                @(posedge clk);
                #1;
                rbus.i_start = 1'b0;
                w = 0;
                while (!rbus.o_done && w < 400) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check_eq($sformatf("rand%0d b%0d done_seen", gi, b), 32'(rbus.o_done), 32'd1);
                exp_n = exp_cnt_q.pop_front();
                check_eq($sformatf("rand%0d b%0d edges", gi, b), 32'(r_edges - snap), 32'(exp_n));
                $display("rand%0d H=%0d L=%0d burst %0d: count=%0d edges=%0d", gi, RH, RL, b, exp_n, r_edges - snap);
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            check_eq($sformatf("rand%0d min_low>=L", gi), 32'(min_low >= RL), 32'd1);
            fin = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        int w;
        logic all_fin;

        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_count = '0;
        tick("pre");
        tick("pre");
        push_idle(2);
        tick("reset");
        tick("reset");
        rst = 1'b0;
        push_idle(2);
        drain("reset");
        $display("reset: outputs idle");

        // Three pulses, H=L=4.
        snap = main_edges;
        start(3);
        push_burst(3, 4, 4, BIG);
        push_idle(2);
        drain("n3");
        check_eq("n3 edges", 32'(main_edges - snap), 32'd3);
        $display("burst n=3 edges=%0d", main_edges - snap);

        // Zero-length burst: only a done strobe.
        snap = main_edges;
        start(0);
        push_burst(0, 4, 4, BIG);
        push_idle(3);
        drain("n0");
        check_eq("n0 edges", 32'(main_edges - snap), 32'd0);
        $display("burst n=0 edges=%0d", main_edges - snap);

        // Reset during a burst at cycle 6; nothing follows through cycle 40.
        start(2);
        push_burst(2, 4, 4, 6);
        drain("rst_mid");
        rst = 1'b1;
        push_idle(34);
        tick("rst_mid");
        rst = 1'b0;
        drain("rst_mid");
        $display("burst n=2 aborted by reset at cycle 6");

        // Back-to-back: second start in the done cycle of the first.
        snap = main_edges;
        start(1);
        push_burst(1, 4, 4, BIG);
        drain("b2b");
        start(2);
        push_burst(2, 4, 4, BIG);
        push_idle(2);
        drain("b2b");
        check_eq("b2b edges", 32'(main_edges - snap), 32'd3);
        $display("back-to-back n=1 then n=2 edges=%0d", main_edges - snap);

        // Start while busy.
        snap = main_edges;
        start(1);
        push_burst(1, 4, 4, BIG);
        tick("busy_start");
        tick("busy_start");
        tick("busy_start");
        bus.i_start = 1'b1;
        bus.i_count = 8'd5;
`ifdef PULSE_GEN_RETRIGGER_EN
        push_burst(5, 4, 4, BIG);
`endif
        push_idle(4);
        drain("busy_start");
`ifdef PULSE_GEN_RETRIGGER_EN
        check_eq("busy_start edges", 32'(main_edges - snap), 32'd6);
`else
        check_eq("busy_start edges", 32'(main_edges - snap), 32'd1);
`endif
        $display("start while busy: edges=%0d", main_edges - snap);

        // Two requests while busy: the later one is the one retained.
        start(1);
        push_burst(1, 4, 4, BIG);
        tick("overwrite");
        tick("overwrite");
        bus.i_start = 1'b1;
        bus.i_count = 8'd5;
        tick("overwrite");
        tick("overwrite");
        bus.i_start = 1'b1;
        bus.i_count = 8'd2;
`ifdef PULSE_GEN_RETRIGGER_EN
        push_burst(2, 4, 4, BIG);
`endif
        push_idle(3);
        drain("overwrite");
        $display("overwrite of pending request checked");

        // Reset while a request is pending clears it.
        start(1);
        push_burst(1, 4, 4, 5);
        tick("rst_pend");
        tick("rst_pend");
        bus.i_start = 1'b1;
        bus.i_count = 8'd4;
        tick("rst_pend");
        tick("rst_pend");
        tick("rst_pend");
        rst = 1'b1;
        push_idle(20);
        tick("rst_pend");
        rst = 1'b0;
        drain("rst_pend");
        $display("reset with pending request checked");

        // Reset and start together: reset wins.
        start(2);
        rst = 1'b1;
        push_idle(6);
        tick("rst_start");
        rst = 1'b0;
        drain("rst_start");
        $display("simultaneous reset and start checked");

        // Largest burst the counter allows.
        snap = main_edges;
        start(255);
        push_burst(255, 4, 4, BIG);
        push_idle(2);
        drain("n255");
        check_eq("n255 edges", 32'(main_edges - snap), 32'd255);
        $display("burst n=255 edges=%0d", main_edges - snap);

        w = 0;
        all_fin = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin;
        while (!all_fin && w < 20000) begin
            @(posedge clk);
            #1;
            w++;
            all_fin = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin;
        end
        check_eq("rand_finished", 32'(all_fin), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Produces a clean, registered burst of N rectangular pulses on a single-bit output in response to a one-cycle start strobe. The high and low phase lengths are programmable. It is the transmit-side counterpart of the edge-detection path: it drives signals whose rising edges downstream detectors count. Every pulse is separated by a guaranteed low phase, so each rising edge is individually detectable by a clocked edge detector in the same clock domain.

## Interface
- HIGH_CYCLES, 4, clock cycles o_sig is held high per pulse (legal range: 1 or more)
- LOW_CYCLES, 4, clock cycles o_sig is held low after each pulse (legal range: 1 or more)
- CNT_W, 8, width of the pulse-count input
- i_clk  input  1  clock; all logic on its rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_start  input  1  one-cycle strobe requesting a burst
- i_count  input  CNT_W  number of pulses in the burst, sampled with i_start
- o_sig  output  1  generated pulse train, driven directly from a flop
- o_busy  output  1  high while a burst is in progress
- o_done  output  1  one-cycle strobe at burst completion

## Operation
- States: IDLE, HIGH, LOW.
- IDLE, i_start=1, i_count≥1:
  - Load remaining = i_count−1.
  - Load the phase counter.
  - Next state HIGH.
- IDLE, i_start=1, i_count=0:
  - Stay in IDLE; o_sig and o_busy stay low.
  - o_done pulses in the next cycle.
- HIGH: o_sig=1 for HIGH_CYCLES cycles, then go to LOW.
- LOW: o_sig=0 for LOW_CYCLES cycles. Then:
  - if remaining>0: decrement remaining, go to HIGH;
  - else: go to IDLE and assert o_done for one cycle.
- o_busy=1 exactly in HIGH and LOW.
- i_start while busy: handling depends on configuration (see below).
- The phase counter is $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1) bits wide and counts down to 1. It never wraps.
- The remaining counter is CNT_W bits wide. The maximum burst is 2^CNT_W−1 pulses, with no overflow.
- Reset values: o_sig=0, o_busy=0, o_done=0, state IDLE, counters 0, pending request cleared.
- Reset mid-burst: on the next edge o_sig drops to 0 and the state returns to IDLE. No o_done is generated for the aborted burst.
- i_rst and i_start in the same cycle: reset wins and the start is dropped.

## Timing
- Take i_start sampled high at edge E0.
- o_sig and o_busy rise at E0+1.
- Pulse k (0-based) is high for edges E0+1+k·(H+L) through E0+k·(H+L)+H.
- The total busy duration is N·(H+L) cycles.
- o_done is high for the single cycle beginning at edge E0+1+N·(H+L); o_busy is low in that cycle.
- i_start in the o_done cycle is accepted (the state is IDLE). This allows back-to-back bursts with a gap of exactly one cycle of low o_sig beyond the LOW phase.
- For i_count=0, o_done is high for the cycle beginning at E0+1.
- Rising edges on o_sig per burst = i_count. The minimum low time between edges is LOW_CYCLES.

## Configuration
- PULSE_GEN_RETRIGGER_EN defined:
  - A one-deep pending request register captures i_start/i_count received while busy.
  - A later request overwrites an earlier pending one.
  - On completion, o_done pulses and the pending burst starts in the same cycle. Its o_sig rise occurs at the next edge.
  - The pending request is cleared by reset.
- Not defined: i_start while busy is ignored, and no pending register is synthesized.

## Test plan
- Reset, then i_start with i_count=3 (H=L=4) at E0 -> o_sig high for cycles 1–4, 9–12 and 17–20; o_busy high for cycles 1–24; o_done high only at cycle 25; 3 rising edges.
- i_start with i_count=0 -> o_sig and o_busy stay 0; o_done high at cycle 1 only.
- i_count=2 burst, then i_rst at cycle 6 -> o_sig=0 and o_busy=0 from cycle 7; no o_done through cycle 40.
- i_count=1, then a second i_start with i_count=2 at the o_done cycle (cycle 9) -> the second burst has o_sig high for cycles 10–13 and 18–21, and o_done at cycle 26.
- i_start with i_count=5 at cycle 3 of an ongoing count=1 burst:
  - without PULSE_GEN_RETRIGGER_EN -> ignored; single pulse, o_done at cycle 9;
  - with it -> o_done at cycle 9, and 5 more pulses starting at cycle 10.
- Random H, L in 1..8 and count in 0..20, with o_sig looped into a clocked rising-edge counter -> counted edges equal i_count for every burst, and the low time between pulses is at least LOW_CYCLES.
